axi_arbiter: RTL and testbench
==============================

AXI_ARBITER -- requirements
Module: axi_arbiter

Interface
REQ-001 The block SHALL have parameter AXI_ID, default 4'h0, the constant ID driven on awid/arid.
REQ-002 The block SHALL have ports clock, input, 1, the sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: synchronous, active-low; sampled on the clock edge, state resets when reset==0.
REQ-004 The block SHALL have IFU port ifu_req_valid/ifu_req_ready (in/out, 1 each) and ifu_req_addr (in, 32), a read-only word fetch request.
REQ-005 The block SHALL have IFU response ports ifu_resp_valid (out, 1), ifu_resp_data (out, 32) and ifu_resp_err (out, 1).
REQ-006 The block SHALL have LSU request ports lsu_req_valid/lsu_req_ready (in/out, 1), lsu_req_we (in, 1), lsu_req_addr (in, 32), lsu_req_wdata (in, 32), lsu_req_wstrb (in, 4) and lsu_req_size (in, 3).
REQ-007 The block SHALL have LSU response ports lsu_resp_valid (out, 1), lsu_resp_data (out, 32) and lsu_resp_err (out, 1).
REQ-008 The block SHALL have downstream AXI4 master ports io_master_{aw,w,b,ar,r}*, with widths exactly as on the core top-level master port.

Function
REQ-009 The block SHALL keep at most one downstream transaction outstanding.
REQ-010 The block SHALL have states IDLE, AR, R, AWW, B and RESP.
REQ-011 In IDLE, one requester SHALL be granted when one or more request valids are high; req_ready SHALL be high combinationally, for that requester only, in that cycle.
REQ-012 Arbitration SHALL be round-robin via register last_grant (reset value IFU): on a simultaneous request, the requester that is not last_grant wins; a single requester wins immediately.
REQ-013 On the grant cycle the block SHALL latch addr, we, wdata, wstrb and size (IFU: we=0, size=3'b010, wstrb=4'hF) and update last_grant.
REQ-014 The grant SHALL move IDLE->AR on a read or IDLE->AWW on a write; the first downstream valid SHALL be asserted the cycle after the grant.
REQ-015 In AR the block SHALL hold arvalid=1 with araddr=latched addr, arlen=0, arsize=latched size, arburst=2'b01 and arid=AXI_ID; arvalid&&arready SHALL move AR->R.
REQ-016 In R the block SHALL hold rready=1; rvalid SHALL capture rdata and set err=(rresp!=0)||(rlast==0), then move R->RESP.
REQ-017 In AWW the block SHALL hold awvalid and wvalid together, with wlast=1, wdata/wstrb latched and awlen=0.
REQ-018 Each valid SHALL drop independently on its own handshake; AWW->B SHALL occur once both handshakes have completed, in either order or in the same cycle.
REQ-019 In B the block SHALL hold bready=1; bvalid SHALL set err=(bresp!=0) and move B->RESP.
REQ-020 In RESP the granted requester's resp_valid SHALL be high for exactly one cycle, with data (0 for writes) and err; the next state SHALL be IDLE.
REQ-021 The non-granted requester's resp_valid SHALL remain 0 at all times.
REQ-022 No new grant SHALL occur before IDLE, so minimum request-to-request spacing is 4 cycles for reads (AR,R,RESP,IDLE) with zero-wait slaves.
REQ-023 A requester dropping req_valid while it is not granted SHALL have no effect; a requester has no way to withdraw a granted request.
REQ-024 All AXI outputs not listed (awburst=2'b01, awsize=latched size, awid=AXI_ID) SHALL be constant as stated; all valids SHALL be 0 outside their states.
REQ-025 rready and bready SHALL be 0 outside R and B respectively.

Reset
REQ-026 While reset==0, the clock edge SHALL force state=IDLE, last_grant=IFU, and all valid/ready/resp outputs to 0 from the following cycle on.
REQ-027 While reset==0, data/err outputs SHALL read 0.
REQ-028 A reset mid-transaction SHALL abandon it without completing handshakes; the downstream slave is reset together with the block.

Verification
REQ-029 IFU-only read: IFU addr 0x30000000 with zero-wait slave rdata 0x00000413 -> arvalid at cycle+1, ifu_resp_valid one cycle with data 0x00000413, err 0.
REQ-030 Simultaneous IFU+LSU after reset -> LSU granted first (last_grant=IFU), IFU next; next simultaneous pair -> LSU again.
REQ-031 LSU write addr 0x80000004, wdata 0xDEADBEEF, wstrb 4'b0011, with awready delayed 3 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid after 4; B entered once both complete; lsu_resp_valid with err 0.
REQ-032 Read with rresp=2'b10 -> resp_err=1; write with bresp=2'b11 -> resp_err=1; read with rlast=0 -> resp_err=1.
REQ-033 Reset asserted low while in R -> next cycle all valids 0, state IDLE; a new IFU request after release completes normally.
REQ-034 Randomized back-to-back traffic from both requesters against a scoreboard -> one outstanding transaction at all times, every request answered exactly once, no starvation beyond one other grant.

Source files
------------

// File: rtl/axi_arbiter.sv
// Arbitrates IFU fetches and LSU loads/stores onto one AXI4 master, one transaction at a time.
// Requests are accepted only in IDLE; the requester's response is one RESP cycle after the AXI reply.
module axi_arbiter #(
    parameter logic [3:0] AXI_ID = 4'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_req_addr,
    output logic        ifu_resp_valid,
    output logic [31:0] ifu_resp_data,
    output logic        ifu_resp_err,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic        lsu_req_we,
    input  logic [31:0] lsu_req_addr,
    input  logic [31:0] lsu_req_wdata,
    input  logic [3:0]  lsu_req_wstrb,
    input  logic [2:0]  lsu_req_size,
    output logic        lsu_resp_valid,
    output logic [31:0] lsu_resp_data,
    output logic        lsu_resp_err,
    input  logic        io_master_awready,
    output logic        io_master_awvalid,
    output logic [31:0] io_master_awaddr,
    output logic [3:0]  io_master_awid,
    output logic [7:0]  io_master_awlen,
    output logic [2:0]  io_master_awsize,
    output logic [1:0]  io_master_awburst,
    input  logic        io_master_wready,
    output logic        io_master_wvalid,
    output logic [31:0] io_master_wdata,
    output logic [3:0]  io_master_wstrb,
    output logic        io_master_wlast,
    output logic        io_master_bready,
    input  logic        io_master_bvalid,
    input  logic [1:0]  io_master_bresp,
    input  logic [3:0]  io_master_bid,
    input  logic        io_master_arready,
    output logic        io_master_arvalid,
    output logic [31:0] io_master_araddr,
    output logic [3:0]  io_master_arid,
    output logic [7:0]  io_master_arlen,
    output logic [2:0]  io_master_arsize,
    output logic [1:0]  io_master_arburst,
    output logic        io_master_rready,
    input  logic        io_master_rvalid,
    input  logic [1:0]  io_master_rresp,
    input  logic [31:0] io_master_rdata,
    input  logic        io_master_rlast,
    input  logic [3:0]  io_master_rid
);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AWW, S_B, S_RESP} state_t;
    localparam logic GNT_IFU = 1'b0;
    localparam logic GNT_LSU = 1'b1;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        gnt_q, gnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [2:0]  size_q, size_d;
    logic        aw_pend_q, aw_pend_d;
    logic        w_pend_q, w_pend_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    logic pick_lsu;
    logic do_grant;
    logic unused_ok;

    // Response IDs are ignored: only one transaction is ever in flight.
    assign unused_ok = ^{io_master_rid, io_master_bid};

    // On a tie the requester that did not win last time gets the bus.
    assign pick_lsu      = lsu_req_valid && (!ifu_req_valid || last_grant_q == GNT_IFU);
    assign do_grant      = reset && (state_q == S_IDLE) && (ifu_req_valid || lsu_req_valid);
    assign ifu_req_ready = do_grant && !pick_lsu;
    assign lsu_req_ready = do_grant && pick_lsu;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        size_d       = size_q;
        aw_pend_d    = aw_pend_q;
        w_pend_d     = w_pend_q;
        data_d       = data_q;
        err_d        = err_q;
        case (state_q)
            S_IDLE: begin
                if (do_grant) begin
                    gnt_d        = pick_lsu;
                    last_grant_d = pick_lsu;
                    data_d       = '0;
                    err_d        = 1'b0;
                    if (pick_lsu) begin
                        we_d    = lsu_req_we;
                        addr_d  = lsu_req_addr;
                        wdata_d = lsu_req_wdata;
                        wstrb_d = lsu_req_wstrb;
                        size_d  = lsu_req_size;
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = ifu_req_addr;
                        wdata_d = '0;
                        wstrb_d = 4'hF;
                        size_d  = 3'b010;
                    end
                    if (we_d) begin
                        state_d   = S_AWW;
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                    end else begin
                        state_d = S_AR;
                    end
                end
            end
            S_AR: begin
                if (io_master_arready) state_d = S_R;
            end
            S_R: begin
                if (io_master_rvalid) begin
                    data_d  = io_master_rdata;
                    err_d   = (io_master_rresp != 2'b00) || !io_master_rlast;
                    state_d = S_RESP;
                end
            end
            S_AWW: begin
                // Address and data channels complete independently, in any order.
                if (io_master_awready) aw_pend_d = 1'b0;
                if (io_master_wready)  w_pend_d  = 1'b0;
                if (!aw_pend_d && !w_pend_d) state_d = S_B;
            end
            S_B: begin
                if (io_master_bvalid) begin
                    data_d  = '0;
                    err_d   = (io_master_bresp != 2'b00);
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= GNT_IFU;
            gnt_q        <= GNT_IFU;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            size_q       <= '0;
            aw_pend_q    <= 1'b0;
            w_pend_q     <= 1'b0;
            data_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            size_q       <= size_d;
            aw_pend_q    <= aw_pend_d;
            w_pend_q     <= w_pend_d;
            data_q       <= data_d;
            err_q        <= err_d;
        end
    end

    assign io_master_arvalid = (state_q == S_AR);
    assign io_master_araddr  = addr_q;
    assign io_master_arid    = AXI_ID;
    assign io_master_arlen   = 8'h00;
    assign io_master_arsize  = size_q;
    assign io_master_arburst = 2'b01;
    assign io_master_rready  = (state_q == S_R);

    assign io_master_awvalid = (state_q == S_AWW) && aw_pend_q;
    assign io_master_awaddr  = addr_q;
    assign io_master_awid    = AXI_ID;
    assign io_master_awlen   = 8'h00;
    assign io_master_awsize  = size_q;
    assign io_master_awburst = 2'b01;
    assign io_master_wvalid  = (state_q == S_AWW) && w_pend_q;
    assign io_master_wdata   = wdata_q;
    assign io_master_wstrb   = wstrb_q;
    assign io_master_wlast   = 1'b1;
    assign io_master_bready  = (state_q == S_B);

    assign ifu_resp_valid = (state_q == S_RESP) && (gnt_q == GNT_IFU);
    assign lsu_resp_valid = (state_q == S_RESP) && (gnt_q == GNT_LSU);
    assign ifu_resp_data  = ifu_resp_valid ? data_q : 32'h0;
    assign ifu_resp_err   = ifu_resp_valid && err_q;
    assign lsu_resp_data  = lsu_resp_valid ? data_q : 32'h0;
    assign lsu_resp_err   = lsu_resp_valid && err_q;

endmodule

// File: tb/tb_axi_arbiter.sv
// Scoreboarded bench for axi_arbiter: directed timing checks plus random two-requester traffic.
`timescale 1ns/1ps
module tb_axi_arbiter;

    localparam logic [3:0]  ID  = 4'h3;
    localparam logic [31:0] KEY = 32'h5A5A_1234;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        ifu_req_valid = 1'b0, ifu_req_ready;
    logic [31:0] ifu_req_addr = '0;
    logic        ifu_resp_valid, ifu_resp_err;
    logic [31:0] ifu_resp_data;
    logic        lsu_req_valid = 1'b0, lsu_req_ready, lsu_req_we = 1'b0;
    logic [31:0] lsu_req_addr = '0, lsu_req_wdata = '0;
    logic [3:0]  lsu_req_wstrb = '0;
    logic [2:0]  lsu_req_size = '0;
    logic        lsu_resp_valid, lsu_resp_err;
    logic [31:0] lsu_resp_data;

    logic        awready = 1'b0, awvalid, wready = 1'b0, wvalid, wlast, bready, bvalid = 1'b0;
    logic [31:0] awaddr, wdata;
    logic [3:0]  awid, wstrb, bid = '0;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp = '0, rresp = '0;
    logic        arready = 1'b0, arvalid, rready, rvalid = 1'b0, rlast = 1'b0;
    logic [31:0] araddr, rdata = '0;
    logic [3:0]  arid, rid = '0;

    axi_arbiter #(.AXI_ID(ID)) dut (
        .clock(clk), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_we(lsu_req_we),
        .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
        .lsu_req_size(lsu_req_size),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data), .lsu_resp_err(lsu_resp_err),
        .io_master_awready(awready), .io_master_awvalid(awvalid), .io_master_awaddr(awaddr),
        .io_master_awid(awid), .io_master_awlen(awlen), .io_master_awsize(awsize),
        .io_master_awburst(awburst),
        .io_master_wready(wready), .io_master_wvalid(wvalid), .io_master_wdata(wdata),
        .io_master_wstrb(wstrb), .io_master_wlast(wlast),
        .io_master_bready(bready), .io_master_bvalid(bvalid), .io_master_bresp(bresp),
        .io_master_bid(bid),
        .io_master_arready(arready), .io_master_arvalid(arvalid), .io_master_araddr(araddr),
        .io_master_arid(arid), .io_master_arlen(arlen), .io_master_arsize(arsize),
        .io_master_arburst(arburst),
        .io_master_rready(rready), .io_master_rvalid(rvalid), .io_master_rresp(rresp),
        .io_master_rdata(rdata), .io_master_rlast(rlast), .io_master_rid(rid)
    );

    int vec_cnt = 0;
    int miss_cnt = 0;

    // Slave configuration
    int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    bit          rand_dly = 1'b0;
    logic [1:0]  rresp_cfg = 2'b00, bresp_cfg = 2'b00;
    logic        rlast_cfg = 1'b1;
    bit          rforce_en = 1'b0;
    logic [31:0] rforce_dat = '0;
    logic [31:0] rd_addr = '0;

    // Fields of the transaction most recently granted, for downstream checks
    logic [31:0] cur_addr = '0, cur_wdata = '0;
    logic [3:0]  cur_wstrb = '0;
    logic [2:0]  cur_size = '0;

    typedef struct packed { logic [31:0] dat; logic err; } exp_t;
    exp_t ifu_q[$];
    exp_t lsu_q[$];
    exp_t mon_e;
    int   ifu_skip = 0, lsu_skip = 0;
    int   ifu_resp_cnt = 0, lsu_resp_cnt = 0;

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return rforce_en ? rforce_dat : (a ^ KEY);
    endfunction

    // Zero-or-programmable-wait AXI slave; decides its inputs at each falling edge.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        end else begin
            if (arvalid) begin
                arready = (ar_cnt >= ar_dly);
                ar_cnt++;
                if (arready) begin
                    rd_addr = araddr;
                    vec_cnt++;
                    if ({araddr, arsize, arlen, arburst, arid} !== {cur_addr, cur_size, 8'h00, 2'b01, ID}) begin
                        miss_cnt++;
                        $display("FAIL ar_fields: got addr=%h size=%0d len=%0d burst=%0d id=%0d, required addr=%h size=%0d len=0 burst=1 id=%0d",
                                 araddr, arsize, arlen, arburst, arid, cur_addr, cur_size, ID);
                    end
                end
            end else begin
                arready = 0; ar_cnt = 0;
                if (rand_dly) ar_dly = $urandom_range(0, 2);
            end
            if (rready) begin
                rvalid = (r_cnt >= r_dly);
                r_cnt++;
                rdata = rd_model(rd_addr); rresp = rresp_cfg; rlast = rlast_cfg;
            end else begin
                rvalid = 0; r_cnt = 0; rdata = '0; rresp = '0; rlast = 0;
                if (rand_dly) r_dly = $urandom_range(0, 2);
            end
            if (awvalid) begin
                awready = (aw_cnt >= aw_dly);
                aw_cnt++;
                if (awready) begin
                    vec_cnt++;
                    if ({awaddr, awsize, awlen, awburst, awid} !== {cur_addr, cur_size, 8'h00, 2'b01, ID}) begin
                        miss_cnt++;
                        $display("FAIL aw_fields: got addr=%h size=%0d len=%0d burst=%0d id=%0d, required addr=%h size=%0d len=0 burst=1 id=%0d",
                                 awaddr, awsize, awlen, awburst, awid, cur_addr, cur_size, ID);
                    end
                end
            end else begin
                awready = 0; aw_cnt = 0;
                if (rand_dly) aw_dly = $urandom_range(0, 2);
            end
            if (wvalid) begin
                wready = (w_cnt >= w_dly);
                w_cnt++;
                if (wready) begin
                    vec_cnt++;
                    if ({wdata, wstrb, wlast} !== {cur_wdata, cur_wstrb, 1'b1}) begin
                        miss_cnt++;
                        $display("FAIL w_fields: got data=%h strb=%b last=%b, required data=%h strb=%b last=1",
                                 wdata, wstrb, wlast, cur_wdata, cur_wstrb);
                    end
                end
            end else begin
                wready = 0; w_cnt = 0;
                if (rand_dly) w_dly = $urandom_range(0, 2);
            end
            if (bready) begin
                bvalid = (b_cnt >= b_dly);
                b_cnt++;
                bresp = bresp_cfg;
            end else begin
                bvalid = 0; b_cnt = 0; bresp = '0;
                if (rand_dly) b_dly = $urandom_range(0, 2);
            end
        end
    end

    // Scoreboard: push expectations at grant, pop and compare at response.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            ifu_q.delete(); lsu_q.delete();
            ifu_skip = 0; lsu_skip = 0;
        end else begin
            if (!ifu_req_valid) ifu_skip = 0;
            if (!lsu_req_valid) lsu_skip = 0;
            if (ifu_resp_valid || lsu_resp_valid) begin
                vec_cnt++;
                if (ifu_resp_valid && lsu_resp_valid) begin
                    miss_cnt++;
                    $display("FAIL resp_onehot: got both resp_valid high, required at most one");
                end
            end
            if (ifu_resp_valid) begin
                ifu_resp_cnt++;
                vec_cnt++;
                if (ifu_q.size() == 0) begin
                    miss_cnt++;
                    $display("FAIL ifu_resp_spurious: got data=%h err=%b, required no response", ifu_resp_data, ifu_resp_err);
                end else begin
                    mon_e = ifu_q.pop_front();
                    if ({ifu_resp_data, ifu_resp_err} !== {mon_e.dat, mon_e.err}) begin
                        miss_cnt++;
                        $display("FAIL ifu_resp: got data=%h err=%b, required data=%h err=%b",
                                 ifu_resp_data, ifu_resp_err, mon_e.dat, mon_e.err);
                    end
                end
            end
            if (lsu_resp_valid) begin
                lsu_resp_cnt++;
                vec_cnt++;
                if (lsu_q.size() == 0) begin
                    miss_cnt++;
                    $display("FAIL lsu_resp_spurious: got data=%h err=%b, required no response", lsu_resp_data, lsu_resp_err);
                end else begin
                    mon_e = lsu_q.pop_front();
                    if ({lsu_resp_data, lsu_resp_err} !== {mon_e.dat, mon_e.err}) begin
                        miss_cnt++;
                        $display("FAIL lsu_resp: got data=%h err=%b, required data=%h err=%b",
                                 lsu_resp_data, lsu_resp_err, mon_e.dat, mon_e.err);
                    end
                end
            end
            if (ifu_req_ready || lsu_req_ready) begin
                vec_cnt++;
                if ((ifu_req_ready && !ifu_req_valid) || (lsu_req_ready && !lsu_req_valid) || (ifu_req_ready && lsu_req_ready)) begin
                    miss_cnt++;
                    $display("FAIL grant_onehot: got ready ifu=%b lsu=%b with valid ifu=%b lsu=%b, required one ready on a valid requester",
                             ifu_req_ready, lsu_req_ready, ifu_req_valid, lsu_req_valid);
                end
                vec_cnt++;
                if (ifu_q.size() + lsu_q.size() != 0) begin
                    miss_cnt++;
                    $display("FAIL outstanding: got %0d unanswered before new grant, required 0", ifu_q.size() + lsu_q.size());
                end
                vec_cnt++;
                if (ifu_req_ready) begin
                    if (ifu_skip > 1) begin
                        miss_cnt++;
                        $display("FAIL starve_ifu: got %0d other grants while waiting, required at most 1", ifu_skip);
                    end
                    ifu_skip = 0;
                    if (lsu_req_valid) lsu_skip++;
                    ifu_q.push_back('{dat: rd_model(ifu_req_addr), err: (rresp_cfg != 2'b00) || !rlast_cfg});
                    cur_addr = ifu_req_addr; cur_size = 3'b010; cur_wstrb = 4'hF; cur_wdata = '0;
                end else begin
                    if (lsu_skip > 1) begin
                        miss_cnt++;
                        $display("FAIL starve_lsu: got %0d other grants while waiting, required at most 1", lsu_skip);
                    end
                    lsu_skip = 0;
                    if (ifu_req_valid) ifu_skip++;
                    if (lsu_req_we)
                        lsu_q.push_back('{dat: 32'h0, err: (bresp_cfg != 2'b00)});
                    else
                        lsu_q.push_back('{dat: rd_model(lsu_req_addr), err: (rresp_cfg != 2'b00) || !rlast_cfg});
                    cur_addr = lsu_req_addr; cur_size = lsu_req_size;
                    cur_wstrb = lsu_req_wstrb; cur_wdata = lsu_req_wdata;
                end
            end
        end
    end

    task automatic ifu_req(input logic [31:0] a);
        bit ok = 1'b0;
        @(posedge clk); #1;
        ifu_req_valid = 1'b1; ifu_req_addr = a;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (ifu_req_ready) ok = 1'b1;
        end
        @(posedge clk); #1;
        ifu_req_valid = 1'b0;
        vec_cnt++;
        if (!ok) begin
            miss_cnt++;
            $display("FAIL ifu_grant_timeout: got no ready in 100 cycles, required a grant");
        end
    endtask

    task automatic lsu_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws, input logic [2:0] sz);
        bit ok = 1'b0;
        @(posedge clk); #1;
        lsu_req_valid = 1'b1; lsu_req_we = we; lsu_req_addr = a;
        lsu_req_wdata = wd; lsu_req_wstrb = ws; lsu_req_size = sz;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (lsu_req_ready) ok = 1'b1;
        end
        @(posedge clk); #1;
        lsu_req_valid = 1'b0;
        vec_cnt++;
        if (!ok) begin
            miss_cnt++;
            $display("FAIL lsu_grant_timeout: got no ready in 100 cycles, required a grant");
        end
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (ifu_q.size() == 0 && lsu_q.size() == 0) done = 1'b1;
        end
        vec_cnt++;
        if (!done) begin
            miss_cnt++;
            $display("FAIL resp_timeout: got %0d/%0d pending ifu/lsu, required 0/0", ifu_q.size(), lsu_q.size());
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1; reset = 1'b0;
        repeat (2) @(posedge clk);
        #1; reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vec_cnt++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin
            miss_cnt++;
            $display("FAIL reset_ready: got ifu=%b lsu=%b, required 0 0", ifu_req_ready, lsu_req_ready);
        end
        vec_cnt++;
        if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0) begin
            miss_cnt++;
            $display("FAIL reset_axi: got ar=%b r=%b aw=%b w=%b b=%b, required all 0", arvalid, rready, awvalid, wvalid, bready);
        end
        vec_cnt++;
        if ({ifu_resp_valid, lsu_resp_valid, ifu_resp_err, lsu_resp_err, ifu_resp_data, lsu_resp_data} !== 68'h0) begin
            miss_cnt++;
            $display("FAIL reset_resp: got valid=%b%b err=%b%b data=%h/%h, required all 0",
                     ifu_resp_valid, lsu_resp_valid, ifu_resp_err, lsu_resp_err, ifu_resp_data, lsu_resp_data);
        end
        vec_cnt++;
        if ({arid, awid} !== {ID, ID}) begin
            miss_cnt++;
            $display("FAIL reset_ids: got arid=%h awid=%h, required %h", arid, awid, ID);
        end
        @(posedge clk); #1;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; reset = 1'b1;
    endtask

    task automatic test_ifu_read();
        rforce_en = 1'b1; rforce_dat = 32'h0000_0413;
        @(posedge clk); #1;
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h3000_0000;
        @(negedge clk);
        vec_cnt++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
            miss_cnt++;
            $display("FAIL ifu_grant: got ifu=%b lsu=%b, required 1 0", ifu_req_ready, lsu_req_ready);
        end
        @(posedge clk); #1;
        ifu_req_valid = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if ({arvalid, araddr, arsize, arlen, arburst} !== {1'b1, 32'h3000_0000, 3'b010, 8'h00, 2'b01}) begin
            miss_cnt++;
            $display("FAIL ifu_ar: got valid=%b addr=%h size=%0d len=%0d burst=%0d, required 1 30000000 2 0 1",
                     arvalid, araddr, arsize, arlen, arburst);
        end
        @(negedge clk);
        vec_cnt++;
        if ({arvalid, rready} !== 2'b01) begin
            miss_cnt++;
            $display("FAIL ifu_r: got arvalid=%b rready=%b, required 0 1", arvalid, rready);
        end
        @(negedge clk);
        vec_cnt++;
        if ({ifu_resp_valid, ifu_resp_data, ifu_resp_err, lsu_resp_valid} !== {1'b1, 32'h0000_0413, 1'b0, 1'b0}) begin
            miss_cnt++;
            $display("FAIL ifu_resp_cycle: got valid=%b data=%h err=%b lsu_valid=%b, required 1 00000413 0 0",
                     ifu_resp_valid, ifu_resp_data, ifu_resp_err, lsu_resp_valid);
        end
        @(negedge clk);
        vec_cnt++;
        if (ifu_resp_valid !== 1'b0) begin
            miss_cnt++;
            $display("FAIL ifu_resp_once: got valid=%b a cycle later, required 0", ifu_resp_valid);
        end
        rforce_en = 1'b0;
        wait_idle();
    endtask

    task automatic test_arbitration();
        bit found;
        int gap;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            ifu_req_valid = 1'b1; ifu_req_addr = 32'h3000_0040 + 32'(k * 4);
            lsu_req_valid = 1'b1; lsu_req_we = 1'b0; lsu_req_addr = 32'h8000_0100 + 32'(k * 4);
            lsu_req_size = 3'b010;
            @(negedge clk);
            vec_cnt++;
            if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
                miss_cnt++;
                $display("FAIL tie_lsu_first_%0d: got ifu=%b lsu=%b, required 0 1", k, ifu_req_ready, lsu_req_ready);
            end
            @(posedge clk); #1;
            lsu_req_valid = 1'b0;
            if (k == 1) ifu_req_valid = 1'b0;
            if (k == 0) begin
                found = 1'b0; gap = 0;
                for (int c = 1; c <= 50 && !found; c++) begin
                    @(negedge clk);
                    if (ifu_req_ready) begin found = 1'b1; gap = c; end
                end
                vec_cnt++;
                if (!found || gap != 4) begin
                    miss_cnt++;
                    $display("FAIL tie_ifu_next: got granted=%b after %0d cycles, required 1 after 4", found, gap);
                end
                @(posedge clk); #1;
                ifu_req_valid = 1'b0;
            end
            wait_idle();
        end
    endtask

    task automatic test_write_delay();
        int t_aw[3] = '{3, 0, 0};
        int t_w[3]  = '{0, 2, 0};
        int e_aw[3] = '{4, 1, 1};
        int e_w[3]  = '{1, 3, 1};
        int e_b[3]  = '{5, 4, 2};
        int aw_hi, w_hi, b_at;
        bit overlap;
        for (int k = 0; k < 3; k++) begin
            aw_dly = t_aw[k]; w_dly = t_w[k];
            lsu_req(1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 4'b0011, 3'b010);
            aw_hi = 0; w_hi = 0; b_at = 0; overlap = 1'b0;
            for (int c = 1; c <= 30 && b_at == 0; c++) begin
                @(negedge clk);
                if (awvalid) aw_hi++;
                if (wvalid) w_hi++;
                if (bready) begin
                    b_at = c;
                    overlap = awvalid || wvalid;
                end
            end
            vec_cnt++;
            if (aw_hi != e_aw[k] || w_hi != e_w[k] || b_at != e_b[k] || overlap) begin
                miss_cnt++;
                $display("FAIL write_chan_%0d: got aw=%0d w=%0d b_at=%0d overlap=%b, required aw=%0d w=%0d b_at=%0d overlap=0",
                         k, aw_hi, w_hi, b_at, overlap, e_aw[k], e_w[k], e_b[k]);
            end
            wait_idle();
        end
        aw_dly = 0; w_dly = 0;
    endtask

    task automatic test_errors();
        rresp_cfg = 2'b10;
        ifu_req(32'h3000_0080);
        wait_idle();
        rresp_cfg = 2'b00;
        bresp_cfg = 2'b11;
        lsu_req(1'b1, 32'h8000_0010, 32'h1234_5678, 4'hF, 3'b010);
        wait_idle();
        bresp_cfg = 2'b00;
        rlast_cfg = 1'b0;
        lsu_req(1'b0, 32'h8000_0020, 32'h0, 4'h0, 3'b001);
        wait_idle();
        rlast_cfg = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit in_r = 1'b0;
        r_dly = 6;
        ifu_req(32'h3000_0100);
        for (int c = 0; c < 20 && !in_r; c++) begin
            @(negedge clk);
            if (rready) in_r = 1'b1;
        end
        vec_cnt++;
        if (!in_r) begin
            miss_cnt++;
            $display("FAIL mid_reach_r: got rready never high, required R state");
        end
        @(posedge clk); #1;
        reset = 1'b0; ifu_req_valid = 1'b1; ifu_req_addr = 32'h3000_0180;
        @(negedge clk);
        @(negedge clk);
        vec_cnt++;
        if ({arvalid, rready, awvalid, wvalid, bready, ifu_resp_valid, lsu_resp_valid, ifu_req_ready} !== 8'h00) begin
            miss_cnt++;
            $display("FAIL mid_reset_outputs: got ar=%b r=%b aw=%b w=%b b=%b resp=%b%b rdy=%b, required all 0",
                     arvalid, rready, awvalid, wvalid, bready, ifu_resp_valid, lsu_resp_valid, ifu_req_ready);
        end
        @(posedge clk); #1;
        ifu_req_valid = 1'b0; reset = 1'b1; r_dly = 0;
        ifu_req(32'h3000_0200);
        wait_idle();
    endtask

    task automatic test_back_to_back();
        ifu_resp_cnt = 0; lsu_resp_cnt = 0;
        rand_dly = 1'b1;
        fork
            begin
                for (int i = 0; i < 25; i++) begin
                    ifu_req($urandom() & 32'hFFFF_FFFC);
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                end
            end
            begin
                for (int j = 0; j < 25; j++) begin
                    lsu_req(1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC, $urandom(),
                            4'($urandom_range(1, 15)), 3'($urandom_range(0, 2)));
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                end
            end
        join
        wait_idle();
        rand_dly = 1'b0;
        vec_cnt++;
        if (ifu_resp_cnt != 25 || lsu_resp_cnt != 25) begin
            miss_cnt++;
            $display("FAIL b2b_counts: got ifu=%0d lsu=%0d responses, required 25 25", ifu_resp_cnt, lsu_resp_cnt);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running at 500us, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_ifu_read();
        test_arbitration();
        test_write_delay();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
